// File: rtl/daw_pkg.sv
// Shared types and constants for the sample playback path.
package daw_pkg;

  localparam int SAMPLE_WIDTH  = 16;
  localparam int DEFAULT_DEPTH = 512;

  typedef enum logic [1:0] {
    READY  = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } reader_state_t;

  // Bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [$clog2(DEFAULT_DEPTH + 1)-1:0] level_t;

endpackage

// File: rtl/pulse_delay.sv
// N-stage single-bit delay line with synchronous reset.
module pulse_delay #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [N-1:0] shift_q, shift_d;

  always_comb begin
    shift_d    = shift_q << 1;
    shift_d[0] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) shift_q <= '0;
    else     shift_q <= shift_d;
  end

  assign dout = shift_q[N-1];

endmodule

// File: rtl/fifo_playback_reader.sv
// Read-side controller for the sample FIFO: one sample per tick, silence on underrun.
// Optional build macro FIFO_READER_PRIME_EN holds playback until the FIFO is half full.
//
// state  | meaning
// READY  | idle, waiting for a tick (or a pending one)
// ISSUE  | fifo_rd high for one cycle, level decremented
// SETTLE | waiting RD_LATENCY+1 cycles for the next head word on fifo_dout
module fifo_playback_reader
  import daw_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int RD_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic                       wr_mon,
  input  logic [WIDTH-1:0]           fifo_dout,
  output logic                       fifo_rd,
  output logic [WIDTH-1:0]           sample_out,
  output logic                       sample_valid,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       underrun,
  output logic                       overflow
);

  localparam int LW = level_width(DEPTH);
  localparam int CW = $clog2(RD_LATENCY + 2);
  localparam logic [LW-1:0] LVL_FULL    = LW'(DEPTH);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(RD_LATENCY + 1);

  reader_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic [WIDTH-1:0] sample_out_q, sample_out_d;
  logic             sample_valid_q, sample_valid_d;
  logic [LW-1:0]    level_q, level_d;
  logic             underrun_q, underrun_d;
  logic             overflow_q, overflow_d;
  logic             wr_mon_q;
  logic             wr_rise, wr_vis, rd_issue, priming;

  assign wr_rise  = wr_mon & ~wr_mon_q;
  assign rd_issue = (state_q == ISSUE);

  // Writes are counted only once the word is guaranteed settled on fifo_dout.
  pulse_delay #(.N(RD_LATENCY + 1)) u_wr_vis (
    .clk  (clk),
    .rst  (rst),
    .din  (wr_rise),
    .dout (wr_vis)
  );

`ifdef FIFO_READER_PRIME_EN
  localparam logic [LW-1:0] LVL_HALF = LW'(DEPTH / 2);
  logic prime_q, prime_d;

  assign priming = prime_q && (level_q < LVL_HALF);
  assign prime_d = priming || underrun_d;

  always_ff @(posedge clk) begin
    if (rst) prime_q <= 1'b1;
    else     prime_q <= prime_d;
  end
`else
  assign priming = 1'b0;
`endif

  always_comb begin
    level_d    = level_q;
    overflow_d = 1'b0;
    if (wr_vis && !rd_issue) begin
      if (level_q == LVL_FULL) overflow_d = 1'b1;
      else                     level_d    = level_q + 1'b1;
    end else if (rd_issue && !wr_vis) begin
      level_d = level_q - 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pending_d      = pending_q;
    fifo_rd_d      = 1'b0;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    underrun_d     = 1'b0;

    // Busy: keep one tick in reserve, drop anything beyond that.
    if (state_q != READY && sample_tick) begin
      if (pending_q) underrun_d = 1'b1;
      else           pending_d  = 1'b1;
    end

    case (state_q)
      READY: begin
        if (sample_tick || pending_q) begin
          pending_d      = pending_q && sample_tick;
          sample_valid_d = 1'b1;
          if (priming) begin
            sample_out_d = '0;
          end else if (level_q != '0) begin
            sample_out_d = fifo_dout;
            fifo_rd_d    = 1'b1;
            state_d      = ISSUE;
          end else begin
            sample_out_d = '0;
            underrun_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d   = SETTLE_LOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= READY;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      fifo_rd_q      <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      level_q        <= '0;
      underrun_q     <= 1'b0;
      overflow_q     <= 1'b0;
      wr_mon_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      fifo_rd_q      <= fifo_rd_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      level_q        <= level_d;
      underrun_q     <= underrun_d;
      overflow_q     <= overflow_d;
      wr_mon_q       <= wr_mon;
    end
  end

  assign fifo_rd      = fifo_rd_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign level        = level_q;
  assign underrun     = underrun_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_fifo_playback_reader.sv
// Directed bench for fifo_playback_reader with a small latency-2 FIFO model.
module tb_fifo_playback_reader;
  import daw_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 512;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_tick = 1'b0;
  logic             wr_mon = 1'b0;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_rd;
  logic [WIDTH-1:0] sample_out;
  logic             sample_valid;
  level_t           level;
  logic             underrun;
  logic             overflow;

  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int ovf_cnt = 0;
  int unr_cnt = 0;
  int base;

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [8:0]       wr_ptr;
  logic [8:0]       rd_ptr;
  logic [WIDTH-1:0] d1, d2;

  always #5 clk = ~clk;

  fifo_playback_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .wr_mon       (wr_mon),
    .fifo_dout    (fifo_dout),
    .fifo_rd      (fifo_rd),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .level        (level),
    .underrun     (underrun),
    .overflow     (overflow)
  );

  // FIFO read side: rd advances the head, dout follows two cycles later.
  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      d1     <= '0;
      d2     <= '0;
    end else begin
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      d1 <= mem[rd_ptr];
      d2 <= d1;
    end
  end
  assign fifo_dout = d2;

  always @(negedge clk) begin
    if (fifo_rd)  rd_cnt++;
    if (overflow) ovf_cnt++;
    if (underrun) unr_cnt++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [WIDTH-1:0] data);
    mem[wr_ptr] = data;
    wr_ptr = wr_ptr + 1'b1;
    wr_mon = 1'b1;
    step(1);
    wr_mon = 1'b0;
    step(1);
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_seq [3];
    exp_seq[0] = 16'h1111;
    exp_seq[1] = 16'h2222;
    exp_seq[2] = 16'h3333;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    wr_ptr = '0;

    rst = 1'b1;
    step(3);
    check_eq("rst_fifo_rd", fifo_rd, 0);
    check_eq("rst_sample_out", sample_out, 0);
    check_eq("rst_sample_valid", sample_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_overflow", overflow, 0);
    rst = 1'b0;
    step(2);

`ifdef FIFO_READER_PRIME_EN
    for (int i = 0; i < 255; i++) do_write(WIDTH'(16'h8000 + i));
    step(5);
    check_eq("prime_level_255", level, 255);
    base = rd_cnt;
    tick();
    check_eq("prime_valid", sample_valid, 1);
    check_eq("prime_zero_out", sample_out, 0);
    check_eq("prime_no_rd", fifo_rd, 0);
    check_eq("prime_no_underrun", underrun, 0);
    step(8);
    check_eq("prime_rd_count", rd_cnt - base, 0);
    do_write(16'h80FF);
    step(5);
    check_eq("prime_level_256", level, 256);
    tick();
    check_eq("prime_first_valid", sample_valid, 1);
    check_eq("prime_first_sample", sample_out, 16'h8000);
    check_eq("prime_first_rd", fifo_rd, 1);
    step(8);
    check_eq("prime_level_after", level, 255);
`else
    // Three writes then three well-spaced ticks.
    base = rd_cnt;
    for (int i = 0; i < 3; i++) do_write(exp_seq[i]);
    step(4);
    check_eq("fill3_level", level, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("play_valid", sample_valid, 1);
      check_eq("play_sample", sample_out, 32'(exp_seq[i]));
      check_eq("play_rd_high", fifo_rd, 1);
      step(1);
      check_eq("play_rd_low", fifo_rd, 0);
      check_eq("play_valid_low", sample_valid, 0);
      step(8);
    end
    check_eq("play_rd_count", rd_cnt - base, 3);
    check_eq("play_level_end", level, 0);

    // Tick on an empty FIFO.
    base = unr_cnt;
    tick();
    check_eq("empty_out", sample_out, 0);
    check_eq("empty_valid", sample_valid, 1);
    check_eq("empty_underrun", underrun, 1);
    check_eq("empty_no_rd", fifo_rd, 0);
    step(1);
    check_eq("empty_underrun_count", unr_cnt - base, 1);

    // Second tick lands in SETTLE and is served once READY returns.
    do_write(16'hAAAA);
    do_write(16'hBBBB);
    step(4);
    check_eq("pend_level", level, 2);
    base = unr_cnt;
    tick();
    check_eq("pend_first", sample_out, 16'hAAAA);
    step(1);
    tick();
    check_eq("pend_wait_a", sample_valid, 0);
    step(2);
    check_eq("pend_wait_b", sample_valid, 0);
    step(1);
    check_eq("pend_valid", sample_valid, 1);
    check_eq("pend_second", sample_out, 16'hBBBB);
    check_eq("pend_rd", fifo_rd, 1);
    step(8);
    check_eq("pend_no_underrun", unr_cnt - base, 0);
    check_eq("pend_level_end", level, 0);

    // wr_vis coinciding with rd_issue leaves level unchanged.
    for (int i = 0; i < 5; i++) do_write(WIDTH'(16'h5000 + i));
    step(5);
    check_eq("simul_level_pre", level, 5);
    mem[wr_ptr] = 16'h5005;
    wr_ptr = wr_ptr + 1'b1;
    wr_mon = 1'b1;
    step(1);
    wr_mon = 1'b0;
    step(1);
    tick();
    check_eq("simul_sample", sample_out, 16'h5000);
    check_eq("simul_level_t1", level, 5);
    step(1);
    check_eq("simul_level_t2", level, 5);
    step(1);
    check_eq("simul_level_t3", level, 5);
    do_write(16'h5006);
    step(2);
    check_eq("simul_level_6", level, 6);
    step(10);
`endif

    // Reset with a write still in the visibility line.
    wr_mon = 1'b1;
    step(1);
    wr_mon = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wr_ptr = '0;
    step(6);
    check_eq("midrst_level", level, 0);
    check_eq("midrst_sample_out", sample_out, 0);

    // Fill to DEPTH, then one write too many.
    base = ovf_cnt;
    for (int i = 0; i < DEPTH; i++) do_write(WIDTH'(i));
    step(5);
    check_eq("full_level", level, 512);
    check_eq("full_no_overflow", ovf_cnt - base, 0);
    do_write(16'hFFFF);
    step(5);
    check_eq("ovf_count", ovf_cnt - base, 1);
    check_eq("ovf_level_hold", level, 512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
